riscv_ahb3_sram_slave: RTL
==========================

RISCV_AHB3_SRAM_SLAVE -- requirements
Module: riscv_ahb3_sram_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 64, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 64, AHB data width (32 or 64).
REQ-003 SHALL have parameter MEM_WORDS, default 256, storage depth in HDATA_SIZE words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, wait cycles per OKAY data phase (0..7).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWDATA  in  HDATA_SIZE  write data (data phase)
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (informational only)
- HPROT  in  4  ignored
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus ready (HREADYIN)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR

Function
REQ-007 Transfer accepted on an HCLK edge where HSEL & HREADY & HTRANS in {NONSEQ,SEQ}; HADDR, HWRITE, HSIZE latched then.
REQ-008 IDLE/BUSY or HSEL=0 with HREADY=1 SHALL give zero-wait OKAY data phase, no storage access.
REQ-009 FSM states IDLE, WAIT, ERR1, ERR2; IDLE->WAIT on good accepted transfer if WAIT_STATES>0; IDLE->ERR1 on bad transfer; WAIT->IDLE after WAIT_STATES cycles; ERR1->ERR2 unconditionally; ERR2->IDLE, or per REQ-007 if a new transfer is accepted in ERR2.
REQ-010 Bad transfer: HSIZE > log2(HDATA_SIZE/8), or HADDR not aligned to HSIZE, or word index >= MEM_WORDS.
REQ-011 OKAY data phase: HREADYOUT=0 for WAIT_STATES cycles, then HREADYOUT=1, HRESP=0.
REQ-012 ERROR: ERR1 HREADYOUT=0,HRESP=1; ERR2 HREADYOUT=1,HRESP=1; bad write SHALL NOT modify storage; bad read drives HRDATA=0.
REQ-013 Write commits on the final data-phase cycle (HREADYOUT=1) using HWDATA and byte lanes from HSIZE and HADDR[log2(HDATA_SIZE/8)-1:0].
REQ-014 Read: HRDATA valid in the cycle HREADYOUT=1, full word returned regardless of HSIZE.
REQ-015 Read-after-write: read whose address phase coincides with a write data phase to same word SHALL return merged new bytes (bypass), zero-wait included.
REQ-016 New transfer SHALL only be accepted with HREADY=1; in WAIT/ERR1 inputs are ignored.
REQ-017 Back-to-back zero-wait transfers SHALL sustain one per cycle.

Reset
REQ-018 On HCLK with HRESET=1: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, latched controls cleared.
REQ-019 Reset mid-data-phase SHALL abandon the transfer; pending write not committed.
REQ-020 Storage contents SHALL NOT be reset.

Structure
REQ-021 HTRANS_*, HSIZE_*, HBURST_*, HRESP_OKAY/ERROR constants SHALL come from riscv_mpsoc_pkg.
REQ-022 Storage SHALL be sub-module riscv_ahb3_sram_ram: single-port, byte-write-enable, one-cycle registered read, no reset.

Verification
REQ-023 WAIT_STATES=0: write 0x1122334455667788 to 0x10 (HSIZE=3), read 0x10 -> HRDATA=0x1122334455667788, HREADYOUT never 0.
REQ-024 Byte write 0xAB to 0x13 (HSIZE=0) over 0 word, read 0x10 -> 0x00000000AB000000.
REQ-025 WAIT_STATES=2: single read -> HREADYOUT low exactly 2 cycles, then high with data.
REQ-026 Read of 0x800 (MEM_WORDS=256) -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (HREADYOUT=1,HRESP=1), HRDATA=0; misaligned HSIZE=2 write at 0x02 -> same, storage unchanged.
REQ-027 Write 0xFF.. to 0x20 followed immediately by read 0x20 -> read returns 0xFF.. (bypass).
REQ-028 HRESET asserted during WAIT of a write to 0x30 -> HREADYOUT=1, HRESP=0 next cycle; read 0x30 returns prior contents.

Source files
------------

// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB3 encodings and the SRAM slave state type.
package riscv_mpsoc_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HWORD   = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HSIZE_DWORD   = 3'b011;
   localparam logic [2:0] HSIZE_B128    = 3'b100;
   localparam logic [2:0] HSIZE_B256    = 3'b101;
   localparam logic [2:0] HSIZE_B512    = 3'b110;
   localparam logic [2:0] HSIZE_B1024   = 3'b111;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } sram_state_t;

endpackage

// File: rtl/riscv_ahb3_sram_ram.sv
// Single-port byte-writable storage with a registered read; no reset.
module riscv_ahb3_sram_ram #(
   parameter int WORDS  = 256,
   parameter int DATA_W = 64
)(
   input  logic                       clk,
   input  logic [$clog2(WORDS)-1:0]   addr,
   input  logic                       re,
   input  logic                       we,
   input  logic [DATA_W/8-1:0]        be,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata
);
   logic [DATA_W-1:0] mem [WORDS];

   // write wins the port; rdata only moves on a read so it holds through wait states
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_W/8; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else if (re) begin
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/riscv_ahb3_sram_slave.sv
// AHB3-Lite SRAM slave: optional wait states, ERROR response for bad transfers,
// posted write buffer so a single-port RAM sustains one transfer per cycle.
module riscv_ahb3_sram_slave
   import riscv_mpsoc_pkg::*;
#(
   parameter int HADDR_SIZE  = 64,
   parameter int HDATA_SIZE  = 64,
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_STATES = 0
)(
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);
   localparam int BE_W  = HDATA_SIZE/8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int AW    = $clog2(MEM_WORDS);
   localparam int WI_W  = HADDR_SIZE - OFF_W;

   sram_state_t       state, nxt_state;
   logic [2:0]        wait_cnt;
   logic              dp_vld, dp_write;
   logic [AW-1:0]     dp_word;
   logic [OFF_W-1:0]  dp_off;
   logic [2:0]        dp_size;
   logic [BE_W-1:0]   dp_be;
   logic              wb_vld;
   logic [AW-1:0]     wb_word;
   logic [BE_W-1:0]   wb_be;
   logic [HDATA_SIZE-1:0] wb_data;
   logic [BE_W-1:0]   byp_be;
   logic [HDATA_SIZE-1:0] byp_data;
   logic              ram_re, ram_we;
   logic [AW-1:0]     ram_addr;
   logic [BE_W-1:0]   ram_be;
   logic [HDATA_SIZE-1:0] ram_wdata, ram_q;
   logic              ap_accept, ap_good, ap_rd, wr_done, port_free;
   logic [OFF_W-1:0]  ap_mask;
   logic [WI_W-1:0]   ap_widx;
   logic [AW-1:0]     ap_word;
   logic              unused_in;

   assign unused_in = ^{HBURST, HPROT, HMASTLOCK};

   // alignment mask: low HSIZE address bits must be zero
   always_comb begin
      ap_mask = '0;
      for (int i = 0; i < OFF_W; i++)
         if (i < int'(HSIZE)) ap_mask[i] = 1'b1;
   end

   assign ap_widx   = HADDR[HADDR_SIZE-1:OFF_W];
   assign ap_word   = HADDR[OFF_W +: AW];
   assign ap_accept = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
                    & (state == ST_IDLE || state == ST_ERR2) & ~HRESET;
   assign ap_good   = (HSIZE <= 3'(OFF_W)) && ((HADDR[OFF_W-1:0] & ap_mask) == '0)
                    && (ap_widx < WI_W'(MEM_WORDS));
   assign ap_rd     = ap_accept & ap_good & ~HWRITE;
   // IDLE with a live data phase is always the last (HREADYOUT=1) cycle
   assign wr_done   = dp_vld & dp_write & (state == ST_IDLE) & ~HRESET;
   assign port_free = ~ap_rd;

   // state register
   always_ff @(posedge HCLK) begin
      if (HRESET) state <= ST_IDLE;
      else        state <= nxt_state;
   end

   // next state and Moore response outputs
   always_comb begin
      nxt_state = state;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state)
         ST_IDLE, ST_ERR2: begin
            if (state == ST_ERR2) HRESP = HRESP_ERROR;
            if (ap_accept)
               nxt_state = !ap_good ? ST_ERR1 : (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
            else
               nxt_state = ST_IDLE;
         end
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_cnt >= 3'(WAIT_STATES)) nxt_state = ST_IDLE;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            nxt_state = ST_ERR2;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // wait counter and latched address-phase controls
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt <= '0;
         dp_vld   <= 1'b0;
         dp_write <= 1'b0;
         dp_word  <= '0;
         dp_off   <= '0;
         dp_size  <= '0;
      end else begin
         if (nxt_state == ST_WAIT) wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd1;
         else                      wait_cnt <= '0;
         if (ap_accept) begin
            dp_vld   <= ap_good;
            dp_write <= HWRITE;
            dp_word  <= ap_word;
            dp_off   <= HADDR[OFF_W-1:0];
            dp_size  <= HSIZE;
         end else if (state == ST_IDLE || state == ST_ERR2) begin
            dp_vld   <= 1'b0;
         end
      end
   end

   // byte lanes covered by the aligned HSIZE block containing the address
   always_comb begin
      dp_be = '0;
      for (int i = 0; i < BE_W; i++)
         if ((i >> dp_size) == (int'(dp_off) >> dp_size)) dp_be[i] = 1'b1;
   end

   // reads own the port when accepted; otherwise drain the posted write, else write directly
   always_comb begin
      ram_re    = ap_rd;
      ram_we    = 1'b0;
      ram_addr  = ap_word;
      ram_be    = wb_be;
      ram_wdata = wb_data;
      if (port_free) begin
         if (wb_vld) begin
            ram_we   = 1'b1;
            ram_addr = wb_word;
         end else if (wr_done) begin
            ram_we    = 1'b1;
            ram_addr  = dp_word;
            ram_be    = dp_be;
            ram_wdata = HWDATA;
         end
      end
   end

   // posted write: park a completing write when the port is taken; drains during reset too
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wb_vld <= 1'b0;
      end else if (wr_done && (!port_free || wb_vld)) begin
         wb_vld  <= 1'b1;
         wb_word <= dp_word;
         wb_be   <= dp_be;
         wb_data <= HWDATA;
      end else if (port_free) begin
         wb_vld  <= 1'b0;
      end
   end

   // snapshot bytes not yet in RAM for the word a read is fetching
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         byp_be   <= '0;
         byp_data <= '0;
      end else if (ap_rd) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wr_done && dp_word == ap_word && dp_be[i]) begin
               byp_be[i]            <= 1'b1;
               byp_data[8*i +: 8]   <= HWDATA[8*i +: 8];
            end else if (wb_vld && wb_word == ap_word && wb_be[i]) begin
               byp_be[i]            <= 1'b1;
               byp_data[8*i +: 8]   <= wb_data[8*i +: 8];
            end else begin
               byp_be[i]            <= 1'b0;
            end
         end
      end
   end

   // read data: RAM word overlaid with bypassed bytes; zero outside a good read
   always_comb begin
      HRDATA = '0;
      if (dp_vld && !dp_write)
         for (int i = 0; i < BE_W; i++)
            HRDATA[8*i +: 8] = byp_be[i] ? byp_data[8*i +: 8] : ram_q[8*i +: 8];
   end

   riscv_ahb3_sram_ram #(
      .WORDS  (MEM_WORDS),
      .DATA_W (HDATA_SIZE)
   ) u_ram (
      .clk   (HCLK),
      .addr  (ram_addr),
      .re    (ram_re),
      .we    (ram_we),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );
endmodule
